masked_sbox_seq: RTL

MASKED_SBOX_SEQ -- requirements
Module: masked_sbox_seq

---
 rtl/midori_mask_pkg.sv | 19 +
 rtl/sbox_lat_tracker.sv | 34 +++
 rtl/masked_sbox_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/midori_mask_pkg.sv
// Shared types and helpers for the three-share masked Midori S-box layer sequencer.
// Nibble 0 is the most significant nibble of a 64-bit share.
package midori_mask_pkg;

    localparam int NIBBLES = 16;
    localparam int SHARE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] nib_sel(input logic [SHARE_W-1:0] v, input logic [3:0] idx);
        return v[SHARE_W-1-4*int'(idx) -: 4];
    endfunction

endpackage

// File: rtl/sbox_lat_tracker.sv
// Valid/index delay line matching the external S-box latency, so each result
// returns tagged with the nibble position it belongs to.
module sbox_lat_tracker #(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_vld,
    input  logic [3:0] issue_idx,
    output logic       wb_vld,
    output logic [3:0] wb_idx
);

    logic [LAT-1:0] vld_q;
    logic [3:0]     idx_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
        end else begin
            vld_q[0] <= issue_vld;
            idx_q[0] <= issue_idx;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign wb_vld = vld_q[LAT-1];
    assign wb_idx = idx_q[LAT-1];

endmodule

// File: rtl/masked_sbox_seq.sv
// Sequences one S-box layer over three separately held Midori state shares,
// feeding one nibble per cycle to an external masked S-box and writing results back in place.
//
// state    | meaning
// IDLE     | waiting; shares may be loaded, start accepted
// RUN      | issuing nibble cnt to the S-box, writebacks may overlap
// DRAIN    | all nibbles issued, waiting for the last results
// DONE     | layer written back, one-cycle done pulse
module masked_sbox_seq
    import midori_mask_pkg::*;
#(
    parameter int SBOX_LAT = 2,
    parameter int NIBBLES  = midori_mask_pkg::NIBBLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [SHARE_W-1:0] sh0_i,
    input  logic [SHARE_W-1:0] sh1_i,
    input  logic [SHARE_W-1:0] sh2_i,
    input  logic               start_i,
    output logic [3:0]         sbox_a_o,
    output logic [3:0]         sbox_b_o,
    output logic [3:0]         sbox_c_o,
    output logic               sbox_vld_o,
    input  logic [3:0]         sbox_x_i,
    input  logic [3:0]         sbox_y_i,
    input  logic [3:0]         sbox_z_i,
    output logic [SHARE_W-1:0] sh0_o,
    output logic [SHARE_W-1:0] sh1_o,
    output logic [SHARE_W-1:0] sh2_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [3:0] LAST = 4'(NIBBLES - 1);

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic [SHARE_W-1:0] sh0, sh1, sh2;
    logic               issue;
    logic               wb_vld;
    logic [3:0]         wb_idx;

    assign issue = (state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i && !load_i) state_nxt = ST_RUN;
            ST_RUN:   if (cnt == LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: if (wb_vld && wb_idx == LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Saturates at the last nibble; cleared whenever the layer is not issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         cnt <= '0;
        else if (!issue)                 cnt <= '0;
        else if (cnt != LAST)            cnt <= cnt + 4'd1;
    end

    sbox_lat_tracker #(
        .LAT (SBOX_LAT)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .issue_vld (issue),
        .issue_idx (cnt),
        .wb_vld    (wb_vld),
        .wb_idx    (wb_idx)
    );

    // Each share is written only from its own S-box output lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh0 <= '0;
            sh1 <= '0;
            sh2 <= '0;
        end else if (state == ST_IDLE && load_i) begin
            sh0 <= sh0_i;
            sh1 <= sh1_i;
            sh2 <= sh2_i;
        end else if (wb_vld) begin
            sh0[SHARE_W-1-4*int'(wb_idx) -: 4] <= sbox_x_i;
            sh1[SHARE_W-1-4*int'(wb_idx) -: 4] <= sbox_y_i;
            sh2[SHARE_W-1-4*int'(wb_idx) -: 4] <= sbox_z_i;
        end
    end

    assign sbox_vld_o = issue;
    assign sbox_a_o   = issue ? nib_sel(sh0, cnt) : 4'h0;
    assign sbox_b_o   = issue ? nib_sel(sh1, cnt) : 4'h0;
    assign sbox_c_o   = issue ? nib_sel(sh2, cnt) : 4'h0;

    assign sh0_o  = sh0;
    assign sh1_o  = sh1;
    assign sh2_o  = sh2;
    assign busy_o = (state == ST_RUN) || (state == ST_DRAIN);
    assign done_o = (state == ST_DONE);

endmodule
